pipe_issue_arbiter: RTL and testbench

//  Shares the 4-register ALU pipeline (ID/EX/WB, 8-bit inst: op[7:6] rs1[5:4] rs2[3:2] rd[1:0])

---
 rtl/pipe_issue_arbiter.sv | 138 +++++++++++++
 tb/tb_pipe_issue_arbiter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/pipe_issue_arbiter.sv
// Round-robin issue arbiter for the shared ALU pipeline: two valid/ready requesters,
// registered issue slot with NOP injection, in-flight write tracking and drain sequencing.
module pipe_issue_arbiter #(
    parameter int INST_W       = 8,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [INST_W-1:0] req0_inst,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [INST_W-1:0] req1_inst,
    output logic              req1_ready,
    input  logic              drain_req,
    output logic [INST_W-1:0] issue_inst,
    output logic              issue_src,
    output logic              issue_valid,
    output logic [3:0]        wr_pending,
    output logic              drained,
    output logic [CNT_W-1:0]  issued_cnt
);

    localparam int NSTAGE = 3;
    localparam int DC_W   = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DRAINED} state_t;

    state_t                   state_reg, state_next;
    logic [DC_W-1:0]          drain_cnt_reg, drain_cnt_next;
    logic                     rr_ptr_reg;
    logic [INST_W-1:0]        issue_inst_reg;
    logic                     issue_valid_reg;
    logic                     issue_src_reg;
    logic [NSTAGE-1:0]        stage_wen_reg;
    logic [NSTAGE-1:0][1:0]   stage_rd_reg;
    logic [CNT_W-1:0]         issued_cnt_reg;

    logic                     accept_en;
    logic                     grant_valid;
    logic                     grant_id;
    logic                     accept;
    logic [INST_W-1:0]        acc_inst;
    logic                     acc_wen;
    logic [3:0][NSTAGE-1:0]   pend_hit;

    // Grant is resolved from the valids alone; accept_en gates it into ready.
    always_comb begin
        accept_en   = rst && (state_reg == ST_RUN) && !drain_req;
        grant_valid = req0_valid || req1_valid;
        grant_id    = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id = rr_ptr_reg;
        end else if (req1_valid) begin
            grant_id = 1'b1;
        end
        req0_ready = accept_en && grant_valid && !grant_id;
        req1_ready = accept_en && grant_valid && grant_id;
        accept     = accept_en && grant_valid;
        acc_inst   = grant_id ? req1_inst : req0_inst;
        acc_wen    = accept && (acc_inst[INST_W-1 -: 2] != 2'b00);
    end

    always_comb begin
        state_next     = state_reg;
        drain_cnt_next = drain_cnt_reg;
        case (state_reg)
            ST_RUN: begin
                if (drain_req) begin
                    state_next     = ST_DRAIN;
                    drain_cnt_next = DC_W'(DRAIN_CYCLES);
                end
            end
            ST_DRAIN: begin
                if (!drain_req) begin
                    state_next = ST_RUN;
                end else if (drain_cnt_reg <= DC_W'(1)) begin
                    state_next     = ST_DRAINED;
                    drain_cnt_next = '0;
                end else begin
                    drain_cnt_next = drain_cnt_reg - DC_W'(1);
                end
            end
            ST_DRAINED: begin
                if (!drain_req) begin
                    state_next = ST_RUN;
                end
            end
            default: state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg       <= ST_RUN;
            drain_cnt_reg   <= '0;
            rr_ptr_reg      <= 1'b0;
            issue_inst_reg  <= '0;
            issue_valid_reg <= 1'b0;
            issue_src_reg   <= 1'b0;
            stage_wen_reg   <= '0;
            stage_rd_reg    <= '0;
            issued_cnt_reg  <= '0;
        end else begin
            state_reg       <= state_next;
            drain_cnt_reg   <= drain_cnt_next;
            issue_inst_reg  <= accept ? acc_inst : '0;
            issue_valid_reg <= accept;
            issue_src_reg   <= accept && grant_id;
            // Stage 0 mirrors the issue register; the upper stages follow ID/EX and EX/WB.
            stage_wen_reg   <= {stage_wen_reg[NSTAGE-2:0], acc_wen};
            stage_rd_reg    <= {stage_rd_reg[NSTAGE-2:0], acc_inst[1:0]};
            if (accept) begin
                rr_ptr_reg <= ~grant_id;
            end
            if (acc_wen) begin
                issued_cnt_reg <= issued_cnt_reg + CNT_W'(1);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_pend
            for (genvar si = 0; si < NSTAGE; si++) begin : g_stage
                assign pend_hit[gi][si] = stage_wen_reg[si] && (stage_rd_reg[si] == 2'(gi));
            end
            assign wr_pending[gi] = |pend_hit[gi];
        end
    endgenerate

    assign issue_inst  = issue_inst_reg;
    assign issue_valid = issue_valid_reg;
    assign issue_src   = issue_src_reg;
    assign drained     = (state_reg == ST_DRAINED);
    assign issued_cnt  = issued_cnt_reg;

endmodule

// File: tb/tb_pipe_issue_arbiter.sv
// Bench for pipe_issue_arbiter: directed scenarios then random traffic, all outputs
// compared each cycle against a cycle-level reference model of the arbiter rules.
module tb_pipe_issue_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid, req1_valid, drain_req;
    logic [7:0]  req0_inst, req1_inst;
    logic        req0_ready, req1_ready;
    logic [7:0]  issue_inst;
    logic        issue_src, issue_valid, drained;
    logic [3:0]  wr_pending;
    logic [15:0] issued_cnt;

    logic        w2_req0_ready, w2_req1_ready;
    logic [7:0]  w2_issue_inst;
    logic        w2_issue_src, w2_issue_valid, w2_drained;
    logic [3:0]  w2_wr_pending;
    logic [1:0]  w2_issued_cnt;

    pipe_issue_arbiter u_dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_inst(req0_inst), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_inst(req1_inst), .req1_ready(req1_ready),
        .drain_req(drain_req),
        .issue_inst(issue_inst), .issue_src(issue_src), .issue_valid(issue_valid),
        .wr_pending(wr_pending), .drained(drained), .issued_cnt(issued_cnt)
    );

    pipe_issue_arbiter #(.CNT_W(2)) u_dut_w2 (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_inst(req0_inst), .req0_ready(w2_req0_ready),
        .req1_valid(req1_valid), .req1_inst(req1_inst), .req1_ready(w2_req1_ready),
        .drain_req(drain_req),
        .issue_inst(w2_issue_inst), .issue_src(w2_issue_src), .issue_valid(w2_issue_valid),
        .wr_pending(w2_wr_pending), .drained(w2_drained), .issued_cnt(w2_issued_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: mode 0=run 1=drain 2=drained; hist[k] = rd written by the issue
    // made k cycles ago, or -1 when that slot carries no register write.
    int          m_mode, m_ptr, m_left, m_src;
    int          hist [3];
    logic [7:0]  m_inst;
    bit          m_val, m_live;
    int unsigned m_cnt;

    task automatic model_reset();
        m_mode = 0; m_ptr = 0; m_left = 0; m_src = 0;
        m_inst = 8'h00; m_val = 1'b0; m_cnt = 0;
        for (int k = 0; k < 3; k++) hist[k] = -1;
    endtask

    task automatic cycle(input bit r, input bit v0, input logic [7:0] i0,
                         input bit v1, input logic [7:0] i1, input bit d);
        int         winner;
        bit         en;
        logic [7:0] ainst;
        logic [3:0] pend;
        rst = r; req0_valid = v0; req0_inst = i0;
        req1_valid = v1; req1_inst = i1; drain_req = d;
        winner = -1;
        if (v0 && v1) winner = m_ptr;
        else if (v0)  winner = 0;
        else if (v1)  winner = 1;
        en = r && (m_mode == 0) && !d;
        pend = 4'b0000;
        for (int k = 0; k < 3; k++) if (hist[k] >= 0) pend[hist[k]] = 1'b1;
        @(negedge clk);
        if (m_live) begin
            check("ready0",     32'(req0_ready),    32'(en && winner == 0));
            check("ready1",     32'(req1_ready),    32'(en && winner == 1));
            check("issue_inst", 32'(issue_inst),    32'(m_inst));
            check("issue_val",  32'(issue_valid),   32'(m_val));
            check("issue_src",  32'(issue_src),     32'(m_src));
            check("wr_pending", 32'(wr_pending),    32'(pend));
            check("drained",    32'(drained),       32'(m_mode == 2));
            check("issued_cnt", 32'(issued_cnt),    m_cnt % 65536);
            check("cnt_w2",     32'(w2_issued_cnt), m_cnt % 4);
        end
        @(posedge clk);
        if (!r) begin
            model_reset();
            m_live = 1'b1;
        end else begin
            ainst = (winner == 1) ? i1 : i0;
            hist[2] = hist[1];
            hist[1] = hist[0];
            if (en && winner >= 0) begin
                hist[0] = (ainst[7:6] != 2'b00) ? int'(ainst[1:0]) : -1;
                m_inst = ainst; m_val = 1'b1; m_src = winner;
                m_ptr = 1 - winner;
                if (ainst[7:6] != 2'b00) m_cnt++;
                $display("accept src=%0d inst=%02h cnt=%0d", winner, ainst, m_cnt);
            end else begin
                hist[0] = -1;
                m_inst = 8'h00; m_val = 1'b0; m_src = 0;
            end
            case (m_mode)
                0: if (d) begin m_mode = 1; m_left = 3; end
                1: if (!d) m_mode = 0;
                   else begin
                       m_left--;
                       if (m_left == 0) m_mode = 2;
                   end
                default: if (!d) m_mode = 0;
            endcase
        end
        #1;
    endtask

    initial begin
        bit d_lvl;
        m_live = 1'b0;
        model_reset();
        // T1: reset then req0 alone is ready on the first live cycle
        cycle(0, 0, 8'h00, 0, 8'h00, 0);
        cycle(0, 0, 8'h00, 0, 8'h00, 0);
        check("t1_inst", 32'(issue_inst), 32'h00);
        check("t1_cnt",  32'(issued_cnt), 32'h0);
        cycle(1, 1, 8'h41, 0, 8'h00, 0);
        // T2: tie alternates 0,1,0,1 from a fresh reset
        cycle(0, 0, 8'h00, 0, 8'h00, 0);
        repeat (4) cycle(1, 1, 8'h41, 1, 8'h86, 0);
        cycle(1, 0, 8'h00, 0, 8'h00, 0);
        check("t2_cnt", 32'(issued_cnt), 32'd4);
        // T3: lone requester 1, then req0 wins the next tie
        repeat (3) cycle(1, 0, 8'h00, 1, 8'hC7, 0);
        cycle(1, 1, 8'h41, 1, 8'h86, 0);
        check("t3_src", 32'(issue_src), 32'd0);
        // T4: single ADD rd=3 stays pending for exactly three cycles
        cycle(1, 0, 8'h00, 0, 8'h00, 0);
        cycle(1, 0, 8'h00, 0, 8'h00, 0);
        cycle(1, 0, 8'h00, 0, 8'h00, 0);
        cycle(1, 0, 8'h00, 0, 8'h00, 0);
        cycle(1, 1, 8'h43, 0, 8'h00, 0);
        repeat (4) cycle(1, 0, 8'h00, 0, 8'h00, 0);
        // T5: drain while streaming, then release
        repeat (3) cycle(1, 1, 8'h41, 0, 8'h00, 0);
        repeat (6) cycle(1, 1, 8'h41, 0, 8'h00, 1);
        check("t5_drained", 32'(drained), 32'd1);
        repeat (3) cycle(1, 1, 8'h41, 0, 8'h00, 0);
        // T6: reset during drain, then counter wrap on the 2-bit instance
        repeat (2) cycle(1, 1, 8'h41, 0, 8'h00, 1);
        cycle(0, 1, 8'h41, 0, 8'h00, 0);
        check("t6_drained", 32'(drained), 32'd0);
        repeat (5) cycle(1, 1, 8'h43, 0, 8'h00, 0);
        cycle(1, 0, 8'h00, 0, 8'h00, 0);
        check("t6_wrap", 32'(w2_issued_cnt), 32'd1);
        check("t6_cnt",  32'(issued_cnt),    32'd5);
        // Random traffic; drain is a level held for stretches so DRAINED is reached
        d_lvl = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(15) == 0) d_lvl = !d_lvl;
            cycle(($urandom_range(63) != 0), 1'($urandom), 8'($urandom),
                  1'($urandom), 8'($urandom), d_lvl);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
